ad5791_multi_dac_streamer: RTL and testbench

//  Serialiser for NUM_DAC AD5791 20-bit DACs sharing one SCLK and one SYNC, with one SDIN line per DAC.

---
 rtl/ad5791_pkg.sv | 24 ++
 rtl/ad5791_sclk_gen.sv | 46 ++++
 rtl/ad5791_multi_dac_streamer.sv | 122 ++++++++++++
 tb/tb_ad5791_multi_dac_streamer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ad5791_pkg.sv
// Shared constants, state encoding and frame helper for the AD5791 streamer.
package ad5791_pkg;

  localparam int FRAME_W = 24;
  localparam int CODE_W  = FRAME_W - 4;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [2:0] ADDR_DAC  = 3'b001;
  localparam logic [2:0] ADDR_CTRL = 3'b010;
  localparam logic       RW_WRITE  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SYNC_HI
  } state_t;

  // Build one serial frame: {R/W, ADDR[2:0], DATA}
  function automatic logic [FRAME_W-1:0] make_frame(input logic [2:0]        addr,
                                                    input logic [CODE_W-1:0] data);
    return {RW_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/ad5791_sclk_gen.sv
// SCLK timing for one frame: half-period counter, SCLK level and bit index.
module ad5791_sclk_gen
  import ad5791_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,      // frame loaded this cycle
  input  logic en,         // frame is shifting
  output logic half_tick,  // last cycle of the current SCLK half-period
  output logic phase,      // SCLK level: 1 = high half, 0 = low half
  output logic last_bit    // bit 0 is on the wire
);

  localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_idx;

  assign half_tick = (cnt == CNT_W'(SCLK_DIV - 1));
  assign last_bit  = (bit_idx == '0);

  // Advance the half-period counter; SCLK toggles and the bit index steps on half ticks
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt     <= '0;
      phase   <= 1'b1;
      bit_idx <= BIT_W'(FRAME_W - 1);
    end else if (start) begin
      cnt     <= '0;
      phase   <= 1'b1;
      bit_idx <= BIT_W'(FRAME_W - 1);
    end else if (en) begin
      if (half_tick) begin
        cnt   <= '0;
        phase <= ~phase;
        // A bit ends at the close of its low half; SCLK returns high for the next one
        if (!phase && !last_bit) bit_idx <= bit_idx - 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ad5791_multi_dac_streamer.sv
// Parallel 24-bit serialiser for NUM_DAC AD5791 DACs sharing SCLK and SYNC.
module ad5791_multi_dac_streamer
  import ad5791_pkg::*;
#(
  parameter int               NUM_DAC   = 4,
  parameter int               DATA_W    = 20,
  parameter int               SCLK_DIV  = 4,
  parameter int               SYNC_HIGH = 4,
  parameter logic [DATA_W-1:0] CTRL_WORD = 20'h00032
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_DAC*DATA_W-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      cfg_req,
  output logic                      PMD_clk,
  output logic                      PMD_sync,
  output logic [NUM_DAC-1:0]        PMD_dac,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      cfg_done
);

  localparam int SH_W = (SYNC_HIGH > 1) ? $clog2(SYNC_HIGH) : 1;

  state_t          state_q, state_n;
  logic            cfg_pend;
  logic            is_ctrl;
  logic            sync_q;
  logic [SH_W-1:0] sh_cnt;
  logic            load_ctrl, load_data, load, frame_end;
  logic            half_tick, phase, last_bit, shift_en;

  ad5791_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (load),
    .en        (state_q == SHIFT),
    .half_tick (half_tick),
    .phase     (phase),
    .last_bit  (last_bit)
  );

  assign load     = load_ctrl | load_data;
  assign shift_en = (state_q == SHIFT) && half_tick && !phase;
  assign s_ready  = (state_q == IDLE) && !cfg_pend;
  assign busy     = (state_q != IDLE);
  assign PMD_clk  = phase;
  assign PMD_sync = sync_q;

  // Next-state decode: control frames win over data, frame ends on the last low half of bit 0
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_n   = state_q;
    load_ctrl = 1'b0;
    load_data = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_pend) begin
          load_ctrl = 1'b1;
          state_n   = SHIFT;
        end else if (s_valid) begin
          load_data = 1'b1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en && last_bit) begin
          frame_end = 1'b1;
          state_n   = SYNC_HI;
        end
      end
      SYNC_HI: begin
        if (sh_cnt == SH_W'(SYNC_HIGH - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, pending/done flags, SYNC pin and inter-frame gap counter
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!aresetn) begin
      state_q    <= IDLE;
      cfg_pend   <= 1'b1;
      is_ctrl    <= 1'b0;
      cfg_done   <= 1'b0;
      frame_done <= 1'b0;
      sync_q     <= 1'b1;
      sh_cnt     <= '0;
    end else begin
      state_q    <= state_n;
      // A request arriving while a control frame loads is kept for another round
      cfg_pend   <= cfg_req | (cfg_pend & ~load_ctrl);
      frame_done <= frame_end;
      if (load) is_ctrl <= load_ctrl;
      if (frame_end && is_ctrl) cfg_done <= 1'b1;
      if (load)           sync_q <= 1'b0;
      else if (frame_end) sync_q <= 1'b1;
      if (frame_end)               sh_cnt <= '0;
      else if (state_q == SYNC_HI) sh_cnt <= sh_cnt + SH_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_DAC; k++) begin : g_lane
    logic [FRAME_W-1:0] sr;

    // Lane shift register: MSB drives SDIN; zeros shift in so the pin idles low after bit 0
    always_ff @(posedge aclk) begin
      // NOTE: the shift register is reset because its MSB is a pad and must idle low.
      if (!aresetn)       sr <= '0;
      else if (load_ctrl) sr <= make_frame(ADDR_CTRL, CTRL_WORD);
      else if (load_data) sr <= make_frame(ADDR_DAC, s_data[k*DATA_W +: DATA_W]);
      else if (shift_en)  sr <= {sr[FRAME_W-2:0], 1'b0};
    end

    assign PMD_dac[k] = sr[FRAME_W-1];
  end

endmodule

// File: tb/tb_ad5791_multi_dac_streamer.sv
// Directed bench for the AD5791 streamer: NUM_DAC=2, SCLK_DIV=2, SYNC_HIGH=3.
module tb_ad5791_multi_dac_streamer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [39:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cfg_req;
  logic        PMD_clk, PMD_sync;
  logic [1:0]  PMD_dac;
  logic        busy, frame_done, cfg_done;

  int checks = 0;
  int failures = 0;

  // Results of the last captured frame
  logic [23:0] lane0, lane1;
  int          low_cnt, fall_cnt, fd_in;

  ad5791_multi_dac_streamer #(
    .NUM_DAC(2), .DATA_W(20), .SCLK_DIV(2), .SYNC_HIGH(3), .CTRL_WORD(20'h00032)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_req(cfg_req), .PMD_clk(PMD_clk), .PMD_sync(PMD_sync), .PMD_dac(PMD_dac),
    .busy(busy), .frame_done(frame_done), .cfg_done(cfg_done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait for SYNC to fall, then record SDIN at every SCLK fall until SYNC rises.
  // Returns at the negedge of the first cycle with SYNC high again.
  task automatic get_frame();
    int   n;
    logic pc;
    lane0 = '0; lane1 = '0; low_cnt = 0; fall_cnt = 0; fd_in = 0; n = 0;
    while (PMD_sync !== 1'b0 && n < 600) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 600) begin
      check("frame_start_timeout", PMD_sync, 0);
      return;
    end
    pc = 1'b1;
    while (PMD_sync === 1'b0 && low_cnt < 300) begin
      low_cnt++;
      if (frame_done) fd_in++;
      if (pc === 1'b1 && PMD_clk === 1'b0) begin
        lane0 = {lane0[22:0], PMD_dac[0]};
        lane1 = {lane1[22:0], PMD_dac[1]};
        fall_cnt++;
      end
      pc = PMD_clk;
      @(negedge aclk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !s_ready) && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 400) check(tag, busy, 0);
  endtask

  // Present one vector while ready; returns at the negedge of the first SHIFT cycle
  task automatic send(input logic [39:0] d);
    wait_idle("send_idle_timeout");
    s_data  = d;
    s_valid = 1'b1;
    @(negedge aclk);
    s_valid = 1'b0;
  endtask

  initial begin
    int acc[3];
    int na, cyc, shi, n, fdc;
    logic [39:0] vec[3];

    aresetn = 1'b0; s_data = '0; s_valid = 1'b0; cfg_req = 1'b0;

    // 1. reset values, then the automatic control frame
    repeat (3) @(negedge aclk);
    check("reset_pins", {PMD_clk, PMD_sync, PMD_dac, s_ready, busy, frame_done, cfg_done}, 8'b1100_0000);
    aresetn = 1'b1;
    get_frame();
    check("t1_lane0", lane0, 24'h200032);
    check("t1_lane1", lane1, 24'h200032);
    check("t1_sync_low", low_cnt, 96);
    check("t1_sclk_falls", fall_cnt, 24);
    check("t1_frame_done", frame_done, 1);
    check("t1_cfg_done", cfg_done, 1);
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("t1_ready_delay", n, 3);

    // 2. one data vector
    send({20'hFFFFF, 20'h12345});
    get_frame();
    check("t2_lane0", lane0, 24'h112345);
    check("t2_lane1", lane1, 24'h1FFFFF);
    check("t2_fd_in_frame", fd_in, 0);
    fdc = 0;
    repeat (5) begin
      if (frame_done) fdc++;
      @(negedge aclk);
    end
    check("t2_fd_pulses", fdc, 1);

    // 3. s_valid held high over three vectors
    vec[0] = {20'h00001, 20'h00002};
    vec[1] = {20'h00003, 20'h00004};
    vec[2] = {20'h00005, 20'h00006};
    na = 0; cyc = 0; shi = 0;
    s_data = vec[0]; s_valid = 1'b1;
    while (na < 3 && cyc < 1000) begin
      if (s_ready) begin
        acc[na] = cyc;
        na++;
        @(negedge aclk);
        cyc++;
        if (na < 3) s_data = vec[na];
        else        s_valid = 1'b0;
      end else begin
        if (na == 1 && busy && PMD_sync) shi++;
        @(negedge aclk);
        cyc++;
      end
    end
    s_valid = 1'b0;
    check("t3_accepts", na, 3);
    if (na == 3) begin
      check("t3_gap_01", acc[1] - acc[0], 100);
      check("t3_gap_12", acc[2] - acc[1], 100);
    end
    check("t3_sync_hi_cycles", shi, 3);

    // 4. cfg_req during bit 10 of a data frame, next vector already valid
    wait_idle("t4_idle_timeout");
    s_data = {20'hABCDE, 20'h5A5A5}; s_valid = 1'b1;
    @(negedge aclk);
    s_data = {20'h13579, 20'h2468A};
    fork
      get_frame();
      begin
        repeat (54) @(negedge aclk);
        cfg_req = 1'b1;
        @(negedge aclk);
        cfg_req = 1'b0;
      end
    join
    check("t4_data_lane0", lane0, 24'h15A5A5);
    check("t4_data_lane1", lane1, 24'h1ABCDE);
    get_frame();
    check("t4_ctrl_lane0", lane0, 24'h200032);
    check("t4_ctrl_lane1", lane1, 24'h200032);
    get_frame();
    s_valid = 1'b0;
    check("t4_pend_lane0", lane0, 24'h12468A);
    check("t4_pend_lane1", lane1, 24'h113579);

    // 5. one-cycle reset at bit 5 of a data frame
    send({20'h11111, 20'h22222});
    check("t5_in_frame", PMD_sync, 0);
    repeat (72) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("t5_mid_reset", {PMD_sync, PMD_clk, busy, cfg_done, PMD_dac}, 6'b110000);
    aresetn = 1'b1;
    get_frame();
    check("t5_ctrl_lane0", lane0, 24'h200032);
    check("t5_ctrl_lane1", lane1, 24'h200032);
    check("t5_cfg_done", cfg_done, 1);

    // 6. s_data changes while the frame shifts
    send({20'h0F0F0, 20'hCAFE1});
    fork
      get_frame();
      begin
        repeat (20) @(negedge aclk);
        s_data = '1;
        repeat (20) @(negedge aclk);
        s_data = '0;
      end
    join
    check("t6_lane0", lane0, 24'h1CAFE1);
    check("t6_lane1", lane1, 24'h10F0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
